// File: rtl/pipe_latch_n.sv
// pipe_latch_n: DEPTH-stage valid/data register pipeline with global stall and
// flush. Per edge the priority is rst > flush > stall > advance. Bubbles
// (in_valid=0) always carry a zero payload so stale data never travels.
// occupancy is a registered count of set valid bits.
//
// Optional feature: define PIPE_LATCH_N_BUBBLE_CNT_EN to add the 16-bit
// saturating bubble_cnt output, which counts advance edges with in_valid=0.
module pipe_latch_n #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
`ifdef PIPE_LATCH_N_BUBBLE_CNT_EN
    output logic [15:0]                bubble_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            valid_reg;
    logic [DEPTH-1:0]            valid_next;
    logic [DEPTH-1:0][WIDTH-1:0] data_reg;
    logic [DEPTH-1:0][WIDTH-1:0] data_next;
    logic [OCC_W-1:0]            occ_reg;
    logic [OCC_W-1:0]            occ_next;

    // Per-stage next state. Stage 0 takes the (zero-masked) input; every
    // later stage takes its predecessor. Flush clears, stall holds.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (gi == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_valid ? in_data : '0;
        end else begin : g_body
            assign src_valid = valid_reg[gi-1];
            assign src_data  = data_reg[gi-1];
        end

        assign valid_next[gi] = flush ? 1'b0 : (stall ? valid_reg[gi] : src_valid);
        assign data_next[gi]  = flush ? '0   : (stall ? data_reg[gi]  : src_data);
    end

    // Population count of the next valid vector, so occupancy can be a
    // register that matches the valid bits right after each edge.
    always_comb begin
        occ_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_next = occ_next + OCC_W'(valid_next[i]);
        end
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            data_reg  <= '0;
            occ_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
            occ_reg   <= occ_next;
        end
    end

    // Outputs come straight from the last stage and the occupancy register.
    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];
    assign occupancy = occ_reg;

`ifdef PIPE_LATCH_N_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_reg;

    // Count advance edges that inject a bubble; saturate, ignore flush/stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_reg <= '0;
        end else if (!flush && !stall && !in_valid && (bubble_cnt_reg != 16'hFFFF)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: doc/pipe_latch_n.md
PIPE_LATCH_N -- requirements
Module: pipe_latch_n

Interface
REQ-001 Parameter WIDTH, default 1: payload bits carried per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 1: number of cascaded register stages; legal range 1..8.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port stall  input  1  1 = every stage holds its contents this cycle.
REQ-006 Port flush  input  1  1 = every stage is invalidated this cycle.
REQ-007 Port in_valid  input  1  qualifies in_data.
REQ-008 Port in_data  input  WIDTH  payload entering stage 0.
REQ-009 Port out_valid  output  1  valid bit of stage DEPTH-1.
REQ-010 Port out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-011 Port occupancy  output  $clog2(DEPTH+1)  count of stages whose valid bit is 1.

Function
REQ-012 Each stage k (0..DEPTH-1) SHALL hold one valid bit and one WIDTH-bit data register, both updated on the rising edge of clk.
REQ-013 Priority per edge SHALL be: rst > flush > stall > advance.
REQ-014 Flush: all valid bits SHALL go to 0 and all data registers to 0; in_data presented in the same cycle SHALL be discarded.
REQ-015 Stall (flush=0): all valid bits and data registers SHALL keep their values; in_data SHALL be discarded.
REQ-016 Advance (flush=0, stall=0): stage 0 SHALL load in_valid and in_data; stage k>0 SHALL load stage k-1.
REQ-017 When in_valid=0 on an advance, stage 0 data SHALL load 0 (a bubble carries zero payload), never stale data.
REQ-018 Latency from an accepted input to out_data SHALL be exactly DEPTH advance cycles; stalled cycles add one each.
REQ-019 out_valid and out_data SHALL be driven directly from stage DEPTH-1 registers with no combinational path from any input.
REQ-020 occupancy SHALL be a registered count equal to the number of set valid bits after each edge; range 0..DEPTH.
REQ-021 With DEPTH=1 and in_valid tied to 1, out_data SHALL equal a plain resettable one-cycle register of in_data.

Reset
REQ-022 On rst=1, without waiting for clk, all valid bits, all data registers, occupancy and (when compiled) bubble_cnt SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight entries; no entry SHALL emerge after reset release.
REQ-024 The first edge after rst deasserts SHALL be treated as a normal cycle under REQ-013.

Configuration
REQ-025 Macro PIPE_LATCH_N_BUBBLE_CNT_EN SHALL gate a bubble counter.
REQ-026 With the macro defined: output port bubble_cnt (16 bits) SHALL increment by 1 on each advance edge with in_valid=0, saturate at 0xFFFF, hold on stall, and be unaffected by flush.
REQ-027 Without the macro: port bubble_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 DEPTH=3, WIDTH=8, no stall/flush, inputs 0x11,0x22,0x33 valid on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 3,4,5 with out_valid=1; occupancy reaches 3.
REQ-029 DEPTH=3, 0xA5 accepted, stall=1 for 2 cycles after its first edge -> 0xA5 appears at output on cycle 5; inputs during stall never appear.
REQ-030 DEPTH=4, pipe full (occupancy=4), flush=1 and stall=1 together one cycle -> next edge occupancy=0, out_valid=0, out_data=0.
REQ-031 DEPTH=2, in_valid=0 with in_data=0xFF for one cycle between valid 0x01 and 0x02 -> output sequence 0x01, bubble (valid 0, data 0x00), 0x02.
REQ-032 DEPTH=8, rst pulsed between clock edges with 5 entries in flight -> outputs 0 immediately; no entry emerges over the next 10 cycles with in_valid=0.
REQ-033 Macro defined, 3 advance cycles with in_valid=0, 1 stalled cycle with in_valid=0, 1 flush cycle -> bubble_cnt=3; forced past 0xFFFF -> holds 0xFFFF.
